// File: rtl/prv_trap_sequencer.sv
// Trap / xRET sequencer between the retire lanes and the privilege CSR block.
// Chooses one event, flushes the pipe, then emits one redirect plus a CSR commit pulse.
module prv_trap_sequencer #(
  parameter int NUM_LANES   = 2,
  parameter int NUM_INT     = 16,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_LANES-1:0]   exc_valid,
  input  logic [NUM_LANES*4-1:0] exc_cause,
  input  logic [NUM_LANES*32-1:0] lane_pc,
  input  logic [NUM_LANES*32-1:0] lane_badaddr,
  input  logic [NUM_INT-1:0]     int_pending,
  input  logic [NUM_INT-1:0]     int_enable,
  input  logic                   global_ie,
  input  logic [31:0]            resume_pc,
  input  logic                   mret,
  input  logic                   sret,
  input  logic [31:0]            mepc_r,
  input  logic [31:0]            sepc_r,
  input  logic [31:0]            xtvec,
  input  logic                   pipe_drained,
  output logic                   pipe_clear,
  output logic                   insert_pc,
  output logic [31:0]            priv_pc,
  output logic                   trap_commit,
  output logic                   ret_commit,
  output logic                   ret_is_s,
  output logic [31:0]            epc,
  output logic [31:0]            cause,
  output logic [31:0]            badaddr,
  output logic                   intr,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, INSERT} state_t;

  state_t state_q, state_d;

  logic        ret_q, ret_s_q;
  logic [31:0] tgt_q;

  // Oldest excepting lane: scan from youngest down so lane 0 wins last.
  logic        exc_any;
  logic [3:0]  sel_code;
  logic [31:0] sel_pc, sel_bad;

  always_comb begin
    exc_any  = 1'b0;
    sel_code = '0;
    sel_pc   = '0;
    sel_bad  = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (exc_valid[i]) begin
        exc_any  = 1'b1;
        sel_code = exc_cause[4*i +: 4];
        sel_pc   = lane_pc[32*i +: 32];
        sel_bad  = lane_badaddr[32*i +: 32];
      end
    end
  end

  // Highest-numbered enabled pending source wins.
  logic [NUM_INT-1:0] int_act;
  logic               int_any;
  logic [31:0]        int_k;

  assign int_act = int_pending & int_enable;
  assign int_any = global_ie & (|int_act);

  always_comb begin
    int_k = '0;
    for (int i = 0; i < NUM_INT; i++)
      if (int_act[i]) int_k = 32'(i);
  end

  logic [31:0] tvec_base;
  logic        vec_mode;

  assign tvec_base = {xtvec[31:2], 2'b00};
  assign vec_mode  = VECTORED_EN && (xtvec[1:0] == 2'b01);

  logic        load_ev, load_rec;
  logic        nxt_ret, nxt_ret_s, nxt_intr;
  logic [31:0] nxt_tgt, nxt_epc, nxt_cause, nxt_bad;

  always_comb begin
    state_d   = state_q;
    load_ev   = 1'b0;
    load_rec  = 1'b0;
    nxt_ret   = 1'b0;
    nxt_ret_s = 1'b0;
    nxt_intr  = 1'b0;
    nxt_tgt   = '0;
    nxt_epc   = '0;
    nxt_cause = '0;
    nxt_bad   = '0;
    case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d   = FLUSH;
          load_ev   = 1'b1;
          load_rec  = 1'b1;
          nxt_tgt   = tvec_base;
          nxt_epc   = sel_pc;
          nxt_cause = {28'b0, sel_code};
          nxt_bad   = sel_bad;
        end else if (mret || sret) begin
          // Returns leave the trap record untouched.
          state_d   = FLUSH;
          load_ev   = 1'b1;
          nxt_ret   = 1'b1;
          nxt_ret_s = !mret;
          nxt_tgt   = mret ? mepc_r : sepc_r;
        end else if (int_any) begin
          state_d   = FLUSH;
          load_ev   = 1'b1;
          load_rec  = 1'b1;
          nxt_intr  = 1'b1;
          nxt_tgt   = vec_mode ? tvec_base + {int_k[29:0], 2'b00} : tvec_base;
          nxt_epc   = resume_pc;
          nxt_cause = {1'b1, 27'b0, int_k[3:0]};
        end
      end
      FLUSH:   if (pipe_drained) state_d = INSERT;
      INSERT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every output is a flop driven from the next state, so each pulse lines up with its state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ret_q       <= 1'b0;
      ret_s_q     <= 1'b0;
      tgt_q       <= '0;
      epc         <= '0;
      cause       <= '0;
      badaddr     <= '0;
      intr        <= 1'b0;
      busy        <= 1'b0;
      pipe_clear  <= 1'b0;
      insert_pc   <= 1'b0;
      priv_pc     <= '0;
      trap_commit <= 1'b0;
      ret_commit  <= 1'b0;
      ret_is_s    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_ev) begin
        ret_q   <= nxt_ret;
        ret_s_q <= nxt_ret_s;
        tgt_q   <= nxt_tgt;
      end
      if (load_rec) begin
        epc     <= nxt_epc;
        cause   <= nxt_cause;
        badaddr <= nxt_bad;
        intr    <= nxt_intr;
      end
      busy        <= (state_d != IDLE);
      pipe_clear  <= (state_d == FLUSH);
      insert_pc   <= (state_d == INSERT);
      priv_pc     <= (state_d == INSERT) ? tgt_q : '0;
      trap_commit <= (state_d == INSERT) && !ret_q;
      ret_commit  <= (state_d == INSERT) && ret_q;
      ret_is_s    <= (state_d == INSERT) && ret_q && ret_s_q;
    end
  end

endmodule

// File: tb/tb_prv_trap_sequencer.sv
// Scoreboard bench: stimulus pushes the expected redirect, a negedge monitor pops it on insert_pc.
module tb_prv_trap_sequencer;
  localparam int NL = 2;
  localparam int NI = 16;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [NL-1:0]  exc_valid;
  logic [NL*4-1:0] exc_cause;
  logic [NL*32-1:0] lane_pc, lane_badaddr;
  logic [NI-1:0]  int_pending, int_enable;
  logic           global_ie, mret, sret, pipe_drained;
  logic [31:0]    resume_pc, mepc_r, sepc_r, xtvec;
  logic           pipe_clear, insert_pc, trap_commit, ret_commit, ret_is_s, intr, busy;
  logic [31:0]    priv_pc, epc, cause, badaddr;

  prv_trap_sequencer #(.NUM_LANES(NL), .NUM_INT(NI), .VECTORED_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .lane_pc(lane_pc), .lane_badaddr(lane_badaddr), .int_pending(int_pending),
    .int_enable(int_enable), .global_ie(global_ie), .resume_pc(resume_pc),
    .mret(mret), .sret(sret), .mepc_r(mepc_r), .sepc_r(sepc_r), .xtvec(xtvec),
    .pipe_drained(pipe_drained), .pipe_clear(pipe_clear), .insert_pc(insert_pc),
    .priv_pc(priv_pc), .trap_commit(trap_commit), .ret_commit(ret_commit),
    .ret_is_s(ret_is_s), .epc(epc), .cause(cause), .badaddr(badaddr),
    .intr(intr), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc, epc, cause, bad;
    logic        trap, ret, ret_s, intr, chk_rec;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic trap, input logic ret, input logic ret_s,
                      input logic chk_rec, input logic [31:0] e_epc, input logic [31:0] e_cause,
                      input logic [31:0] e_bad, input logic e_intr, input int extra);
    exp_t e;
    e.pc = pc; e.trap = trap; e.ret = ret; e.ret_s = ret_s; e.chk_rec = chk_rec;
    e.epc = e_epc; e.cause = e_cause; e.bad = e_bad; e.intr = e_intr;
    e.at = cyc + 2 + extra;
    sb.push_back(e);
  endtask

  task automatic clr_ev();
    exc_valid = '0; mret = 1'b0; sret = 1'b0;
    int_pending = '0; int_enable = '0; global_ie = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},    32'(busy), 0);
    chk({tag, "_clear"},   32'(pipe_clear), 0);
    chk({tag, "_insert"},  32'(insert_pc), 0);
    chk({tag, "_priv_pc"}, priv_pc, 0);
    chk({tag, "_trap"},    32'(trap_commit), 0);
    chk({tag, "_ret"},     32'(ret_commit), 0);
    chk({tag, "_ret_s"},   32'(ret_is_s), 0);
    chk({tag, "_epc"},     epc, 0);
    chk({tag, "_cause"},   cause, 0);
    chk({tag, "_badaddr"}, badaddr, 0);
    chk({tag, "_intr"},    32'(intr), 0);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor
  always @(negedge CLK) begin
    chk("stray_commit", 32'((trap_commit | ret_commit) & !insert_pc), 0);
    if (insert_pc) begin
      if (sb.size() == 0) begin
        chk("unexpected_insert", 32'(insert_pc), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("insert_cycle", 32'(cyc), 32'(mon_e.at));
        chk("priv_pc", priv_pc, mon_e.pc);
        chk("trap_commit", 32'(trap_commit), 32'(mon_e.trap));
        chk("ret_commit", 32'(ret_commit), 32'(mon_e.ret));
        chk("ret_is_s", 32'(ret_is_s), 32'(mon_e.ret_s));
        chk("pipe_clear_at_insert", 32'(pipe_clear), 0);
        if (mon_e.chk_rec) begin
          chk("epc", epc, mon_e.epc);
          chk("cause", cause, mon_e.cause);
          chk("badaddr", badaddr, mon_e.bad);
          chk("intr", 32'(intr), 32'(mon_e.intr));
        end
      end
    end else if (sb.size() != 0 && cyc > sb[0].at) begin
      chk("insert_missing", 32'(insert_pc), 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    clr_ev();
    exc_cause = '0; lane_pc = '0; lane_badaddr = '0;
    resume_pc = '0; mepc_r = '0; sepc_r = '0; xtvec = '0;
    pipe_drained = 1'b1;
    RST = 1'b1;
    wait_n(3);
    chk_zero("reset");
    RST = 1'b0;
    wait_n(2);

    // Two lanes except: lane 0 is oldest and wins
    xtvec = 32'h0000_1000;
    exc_valid = 2'b11;
    exc_cause = {4'd5, 4'd2};
    lane_pc = {32'h104, 32'h100};
    lane_badaddr = {32'hBB, 32'hAA};
    push(32'h1000, 1, 0, 0, 1, 32'h100, 32'h2, 32'hAA, 0, 0);
    @(negedge CLK);
    clr_ev();
    chk("t1_busy", 32'(busy), 1);
    chk("t1_clear", 32'(pipe_clear), 1);
    chk("t1_no_early_insert", 32'(insert_pc), 0);
    @(negedge CLK);
    chk("t1_busy_in_insert", 32'(busy), 1);
    @(negedge CLK);
    chk("t1_busy_fall", 32'(busy), 0);

    // Back-to-back: vectored interrupt presented the cycle busy falls
    int_pending = 16'h0880; int_enable = 16'h0880; global_ie = 1'b1;
    xtvec = 32'h8000_0001; resume_pc = 32'h200;
    push(32'h8000_002C, 1, 0, 0, 1, 32'h200, 32'h8000_000B, 32'h0, 1, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(3);

    // Same interrupt, direct mode
    int_pending = 16'h0880; int_enable = 16'h0880; global_ie = 1'b1;
    xtvec = 32'h8000_0000;
    push(32'h8000_0000, 1, 0, 0, 1, 32'h200, 32'h8000_000B, 32'h0, 1, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(3);

    // Mode 10 falls back to direct
    int_pending = 16'h0080; int_enable = 16'h0080; global_ie = 1'b1;
    xtvec = 32'h8000_0002; resume_pc = 32'h240;
    push(32'h8000_0000, 1, 0, 0, 1, 32'h240, 32'h8000_0007, 32'h0, 1, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(3);

    // Exception beats a pending interrupt and is never vectored
    xtvec = 32'h8000_0001;
    exc_valid = 2'b01; exc_cause = {4'd0, 4'hD};
    lane_pc = {32'h0, 32'h300}; lane_badaddr = {32'h0, 32'h55};
    int_pending = 16'h0800; int_enable = 16'h0800; global_ie = 1'b1;
    push(32'h8000_0000, 1, 0, 0, 1, 32'h300, 32'hD, 32'h55, 0, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(3);

    // mret + sret together with an interrupt pending: mret only
    mret = 1'b1; sret = 1'b1; mepc_r = 32'h400; sepc_r = 32'h500;
    int_pending = 16'h0010; int_enable = 16'h0010; global_ie = 1'b1;
    push(32'h400, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(3);

    sret = 1'b1;
    push(32'h500, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(3);

    // Drain delayed: new exception during FLUSH must not alter the record
    xtvec = 32'h0000_1000;
    pipe_drained = 1'b0;
    exc_valid = 2'b10; exc_cause = {4'd5, 4'd0};
    lane_pc = {32'h104, 32'h0}; lane_badaddr = {32'hBB, 32'h0};
    push(32'h1000, 1, 0, 0, 1, 32'h104, 32'h5, 32'hBB, 0, 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        exc_valid = 2'b01; exc_cause = {4'd0, 4'd3};
        lane_pc = {32'h0, 32'h999}; lane_badaddr = {32'h0, 32'h9};
      end
      chk("t4_clear_held", 32'(pipe_clear), 1);
      if (k == 4) begin
        pipe_drained = 1'b1;
        clr_ev();
      end
    end
    wait_n(3);

    // Reset during the second FLUSH cycle
    pipe_drained = 1'b0;
    exc_valid = 2'b01; exc_cause = {4'd0, 4'd1};
    lane_pc = {32'h0, 32'h600}; lane_badaddr = {32'h0, 32'h66};
    @(negedge CLK);
    clr_ev();
    chk("t5_flush1", 32'(pipe_clear), 1);
    @(negedge CLK);
    RST = 1'b1; pipe_drained = 1'b1;
    @(negedge CLK);
    chk_zero("abort");
    RST = 1'b0;
    @(negedge CLK);
    exc_valid = 2'b10; exc_cause = {4'd7, 4'd0};
    lane_pc = {32'h700, 32'h0}; lane_badaddr = {32'h77, 32'h0};
    push(32'h1000, 1, 0, 0, 1, 32'h700, 32'h7, 32'h77, 0, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(3);

    // global_ie gates interrupts
    xtvec = 32'h0000_2000; resume_pc = 32'h800;
    int_pending = 16'h0008; int_enable = 16'h0008; global_ie = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("t6_gated_busy", 32'(busy), 0);
    end
    global_ie = 1'b1;
    push(32'h2000, 1, 0, 0, 1, 32'h800, 32'h8000_0003, 32'h0, 1, 0);
    @(negedge CLK);
    clr_ev();
    wait_n(6);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
